// File: rtl/sha256_job_arbiter.sv
// Two-requester round-robin arbiter feeding byte jobs into a single SHA-256 core.
// Forwards the granted byte stream, waits for the digest, and reports done/err per requester.
module sha256_job_arbiter #(
  parameter int unsigned MAX_BYTES    = 255,
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  input  logic [7:0]   s_data0,
  input  logic [7:0]   s_data1,
  input  logic [1:0]   s_valid,
  input  logic [1:0]   s_last,
  output logic [1:0]   s_ready,
  output logic         h_start,
  output logic         h_valid,
  output logic         h_last,
  output logic [7:0]   h_data,
  input  logic         h_done,
  input  logic [255:0] h_hash,
  output logic [1:0]   done,
  output logic [1:0]   err,
  output logic [255:0] hash_out,
  output logic         busy
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES);
  localparam logic [CW-1:0] TIMER_MX = CW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESULT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      s_ready_q, s_ready_d;
  logic            h_start_q, h_start_d;
  logic            h_valid_q, h_valid_d;
  logic            h_last_q, h_last_d;
  logic [7:0]      h_data_q, h_data_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [255:0]    hash_q, hash_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic            last_q, last_d;

  logic            win;
  logic            accept;
  logic            end_flag;
  logic [7:0]      sel_byte;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      s_ready_q <= 2'b00;
      h_start_q <= 1'b0;
      h_valid_q <= 1'b0;
      h_last_q  <= 1'b0;
      h_data_q  <= 8'h00;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      hash_q    <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      timer_q   <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      s_ready_q <= s_ready_d;
      h_start_q <= h_start_d;
      h_valid_q <= h_valid_d;
      h_last_q  <= h_last_d;
      h_data_q  <= h_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hash_q    <= hash_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    h_start_d = 1'b0;
    h_valid_d = 1'b0;
    h_last_d  = 1'b0;
    h_data_d  = h_data_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    hash_d    = hash_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    last_d    = last_q;
    win       = 1'b0;

    // s_ready_q is only ever set for the granted requester while streaming
    accept   = |(s_valid & s_ready_q);
    sel_byte = gnt_q[1] ? s_data1 : s_data0;
    end_flag = (|(s_last & gnt_q)) || ((cnt_q + CW'(1)) == MAX_CNT);

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the requester not served last wins
          win     = (req == 2'b11) ? ~last_q : req[1];
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          h_valid_d = 1'b1;
          h_data_d  = sel_byte;
          cnt_d     = cnt_q + CW'(1);
          if (end_flag) begin
            h_last_d  = 1'b1;
            h_start_d = 1'b1;
            timer_d   = '0;
            state_d   = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (h_done) begin
          hash_d  = h_hash;
          done_d  = gnt_q;
          state_d = RESULT;
        end else if (timer_q == TIMER_MX) begin
          err_d   = gnt_q;
          gnt_d   = 2'b00;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      RESULT: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == STREAM) ? gnt_d : 2'b00;
    busy_d    = (state_d != IDLE);
  end

  assign gnt      = gnt_q;
  assign s_ready  = s_ready_q;
  assign h_start  = h_start_q;
  assign h_valid  = h_valid_q;
  assign h_last   = h_last_q;
  assign h_data   = h_data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign hash_out = hash_q;
  assign busy     = busy_q;

endmodule
